// File: rtl/serial_conditional_difference_subtractor_pkg.sv
// Shared sequencing definitions for the conditional-sum adder and subtractor blocks.
// Package name conditional_sum_pkg is common to both sides.
package conditional_sum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Digit counter width: $clog2 of the digit count, never below one bit.
   function automatic int unsigned count_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_conditional_difference_subtractor_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// SUB_OVERFLOW_EN adds the signed overflow flag.
interface serial_conditional_difference_subtractor_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
   logic             overflow;

   modport master (output in_valid, a, b, borrow_in, out_ready,
                   input  in_ready, out_valid, diff, borrow_out, overflow);
   modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                   output in_ready, out_valid, diff, borrow_out, overflow);
`else
   modport master (output in_valid, a, b, borrow_in, out_ready,
                   input  in_ready, out_valid, diff, borrow_out);
   modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                   output in_ready, out_valid, diff, borrow_out);
`endif

endinterface

// File: rtl/serial_conditional_difference_subtractor_digit.sv
// Combinational DIGIT-bit cell: both borrow outcomes are formed up front and the
// incoming borrow only steers the final mux.
module conditional_difference_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             borrow,
   output logic [DIGIT-1:0] diff_d,
   output logic             borrow_next
);

   logic [DIGIT:0] sum0;
   logic [DIGIT:0] sum1;
   logic [DIGIT:0] sel;

   assign sum0 = {1'b0, a_d} + {1'b0, ~b_d} + (DIGIT+1)'(1);
   assign sum1 = {1'b0, a_d} + {1'b0, ~b_d};

   // A borrow out of the digit is the absence of a carry out of the sum.
   assign sel         = borrow ? sum1 : sum0;
   assign diff_d      = sel[DIGIT-1:0];
   assign borrow_next = ~sel[DIGIT];

endmodule

// File: rtl/serial_conditional_difference_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per cycle, LSB first.
// Define SUB_OVERFLOW_EN to add the signed overflow output.
module serial_conditional_difference_subtractor
   import conditional_sum_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic clk,
   input  logic rst,
   serial_conditional_difference_subtractor_if.slave bus
);

   localparam int unsigned NDIG  = WIDTH / DIGIT;
   localparam int unsigned CNT_W = count_width(NDIG);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic [DIGIT-1:0] diff_d;
   logic             borrow_next;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;

   conditional_difference_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d         (a_q[DIGIT-1:0]),
      .b_d         (b_q[DIGIT-1:0]),
      .borrow      (borrow_q),
      .diff_d      (diff_d),
      .borrow_next (borrow_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_next = RUN;
         end
         RUN: begin
            if (count == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = in_ready_c & bus.in_valid;

   // Operands shift down so the active digit is always at bit 0; results enter at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else if (accept) begin
         count    <= '0;
         a_q      <= bus.a;
         b_q      <= bus.b;
         borrow_q <= bus.borrow_in;
      end else if (state == RUN) begin
         count    <= count + CNT_W'(1);
         a_q      <= a_q >> DIGIT;
         b_q      <= b_q >> DIGIT;
         diff_q   <= (diff_q >> DIGIT) | (WIDTH'(diff_d) << (WIDTH - DIGIT));
         borrow_q <= borrow_next;
      end
   end

`ifdef SUB_OVERFLOW_EN
   logic a_sign;
   logic b_sign;
   logic overflow_q;

   // The last digit's top bit is the result sign, so overflow is settled on the RUN->DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sign     <= 1'b0;
         b_sign     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         a_sign <= bus.a[WIDTH-1];
         b_sign <= bus.b[WIDTH-1];
      end else if (state == RUN && count == LAST) begin
         overflow_q <= (a_sign != b_sign) && (diff_d[DIGIT-1] != a_sign);
      end
   end

   assign bus.overflow = overflow_q;
`endif

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_conditional_difference_subtractor.sv
// Bench for serial_conditional_difference_subtractor with DIGIT = 1, 4 and 16 side by side.
// Define SUB_OVERFLOW_EN to also check the overflow output.
module tb_serial_conditional_difference_subtractor;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid;
   logic         borrow_in;
   logic         out_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;

   always #5 clk = ~clk;

   serial_conditional_difference_subtractor_if #(.WIDTH(W)) if1  ();
   serial_conditional_difference_subtractor_if #(.WIDTH(W)) if4  ();
   serial_conditional_difference_subtractor_if #(.WIDTH(W)) if16 ();

   assign if1.in_valid   = in_valid;
   assign if1.a          = a;
   assign if1.b          = b;
   assign if1.borrow_in  = borrow_in;
   assign if1.out_ready  = out_ready;
   assign if4.in_valid   = in_valid;
   assign if4.a          = a;
   assign if4.b          = b;
   assign if4.borrow_in  = borrow_in;
   assign if4.out_ready  = out_ready;
   assign if16.in_valid  = in_valid;
   assign if16.a         = a;
   assign if16.b         = b;
   assign if16.borrow_in = borrow_in;
   assign if16.out_ready = out_ready;

   serial_conditional_difference_subtractor #(.WIDTH(W), .DIGIT(1))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   serial_conditional_difference_subtractor #(.WIDTH(W), .DIGIT(4))
      dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   serial_conditional_difference_subtractor #(.WIDTH(W), .DIGIT(16))
      dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

   logic [2:0]   ov;
   logic [2:0]   ir;
   logic [2:0]   bo;
   logic [2:0]   ofl;
   logic [W-1:0] dv [3];

   assign ov    = {if16.out_valid, if4.out_valid, if1.out_valid};
   assign ir    = {if16.in_ready, if4.in_ready, if1.in_ready};
   assign bo    = {if16.borrow_out, if4.borrow_out, if1.borrow_out};
   assign dv[0] = if1.diff;
   assign dv[1] = if4.diff;
   assign dv[2] = if16.diff;
`ifdef SUB_OVERFLOW_EN
   assign ofl   = {if16.overflow, if4.overflow, if1.overflow};
`else
   assign ofl   = '0;
`endif

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           n_cmp;
   int           n_bad;
   logic [W-1:0] exp_diff;
   logic         exp_borrow;
   logic         exp_of;
   int           op_seq;
   int           done_seq [3];
   int unsigned  start [3];
   int unsigned  lat [3];
   logic [2:0]   pv;
   logic [2:0]   pr;
   logic [W-1:0] pd [3];
   logic         rand_rdy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain wide arithmetic, signed range test for overflow.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                        output logic [W-1:0] d, output logic brw, output logic of);
      int full;
      int s;
      full = int'(x) - int'(y) - int'(bin);
      d    = W'(full);
      brw  = (full < 0);
      s    = int'($signed(x)) - int'($signed(y)) - int'(bin);
      of   = (s > 32767) || (s < -32768);
   endtask

   task automatic pin_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                            input logic [W-1:0] d_lit, input logic b_lit, input logic o_lit);
      logic [W-1:0] d;
      logic         brw;
      logic         of;
      model(x, y, bin, d, brw, of);
      chk("model_diff", 32'(d), 32'(d_lit));
      chk("model_borrow", 32'(brw), 32'(b_lit));
      chk("model_overflow", 32'(of), 32'(o_lit));
   endtask

   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
      int t;
      t = 0;
      while (ir != 3'b111 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (ir != 3'b111) chk("wait_in_ready", 32'(ir), 32'h7);
      model(x, y, bin, exp_diff, exp_borrow, exp_of);
      op_seq++;
      a         = x;
      b         = y;
      borrow_in = bin;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!(done_seq[0] == op_seq && done_seq[1] == op_seq && done_seq[2] == op_seq) && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 400) chk("wait_done_timeout", 32'(t), 32'd0);
   endtask

   task automatic run_lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                          input logic [W-1:0] d_lit, input logic b_lit);
      start_op(x, y, bin);
      wait_done();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lit_diff[%0d]", i), 32'(dv[i]), 32'(d_lit));
         chk($sformatf("lit_borrow[%0d]", i), 32'(bo[i]), 32'(b_lit));
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      op_seq    = 0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      out_ready = 1'b1;
      rand_rdy  = 1'b0;
      pv        = '0;
      pr        = '0;
      lat[0] = 16; lat[1] = 4; lat[2] = 1;
      for (int i = 0; i < 3; i++) begin
         done_seq[i] = 0;
         start[i]    = 0;
         pd[i]       = '0;
      end

      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               if (!rst) begin
                  if (in_valid && ir[i]) start[i] = cyc;
                  if (ov[i]) begin
                     chk($sformatf("diff[%0d]", i), 32'(dv[i]), 32'(exp_diff));
                     chk($sformatf("borrow_out[%0d]", i), 32'(bo[i]), 32'(exp_borrow));
`ifdef SUB_OVERFLOW_EN
                     chk($sformatf("overflow[%0d]", i), 32'(ofl[i]), 32'(exp_of));
`endif
                     chk($sformatf("in_ready_in_done[%0d]", i), 32'(ir[i]), 32'd0);
                     if (!pv[i]) chk($sformatf("latency[%0d]", i), cyc - start[i], lat[i] + 1);
                     if (out_ready) done_seq[i] = op_seq;
                  end
                  if (pv[i] && !pr[i]) begin
                     chk($sformatf("hold_valid[%0d]", i), 32'(ov[i]), 32'd1);
                     chk($sformatf("hold_diff[%0d]", i), 32'(dv[i]), 32'(pd[i]));
                  end
               end
               pv[i] = rst ? 1'b0 : ov[i];
               pr[i] = out_ready;
               pd[i] = dv[i];
            end
         end
         forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         end
      join_none

      // Reset state
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
         chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
         chk($sformatf("rst_diff[%0d]", i), 32'(dv[i]), 32'd0);
         chk($sformatf("rst_borrow[%0d]", i), 32'(bo[i]), 32'd0);
         chk($sformatf("rst_overflow[%0d]", i), 32'(ofl[i]), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Hand-computed anchors for the reference model
      pin_model(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
      pin_model(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      pin_model(16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b1);
      pin_model(16'h1234, 16'h0F0F, 1'b1, 16'h0324, 1'b0, 1'b0);
      pin_model(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);

      // Directed vectors
      run_lit(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
      run_lit(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
      run_lit(16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0);
      run_lit(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0);

      // Backpressure in DONE with input noise
      out_ready = 1'b0;
      start_op(16'h1234, 16'h0F0F, 1'b1);
      for (int t = 0; t < 40 && ov != 3'b111; t++) begin
         @(posedge clk); #1;
      end
      chk("all_done_reached", 32'(ov), 32'h7);
      for (int t = 0; t < 10; t++) begin
         in_valid = ~in_valid;
         a        = W'($urandom);
         @(posedge clk); #1;
         chk("hold_in_ready", 32'(ir), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_done();
      for (int i = 0; i < 3; i++)
         chk($sformatf("hold_result[%0d]", i), 32'(dv[i]), 32'h0324);

      // Reset during RUN
      start_op(16'hABCD, 16'h1234, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
         chk($sformatf("abort_diff[%0d]", i), 32'(dv[i]), 32'd0);
         chk($sformatf("abort_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_lit(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

      // Random operands with random consumer stalls
      rand_rdy = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         wait_done();
      end
      rand_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
